mips_register_file: RTL
=======================

// Module: mips_register_file
// PURPOSE
//  - 32-entry general-purpose register file for the MIPS single-cycle datapath.
//  - Two combinational read ports feed the ALU-source and write-data selection muxes.
//  - One synchronous write port is driven by the write-back mux.
//  - Register $0 is hardwired to zero; all other registers clear on reset.
// PARAMETERS
//  - DATA_W  32  width of every register and data port
//  - ADDR_W  5   register index width; depth = 2**ADDR_W
//  - BYPASS  0   1: a read of the register being written this cycle returns WD (write-through)
// PORTS
//  - clk    in   1       rising-edge clock
//  - rst_n  in   1       asynchronous, active-low reset
//  - RA1    in   ADDR_W  read address, port 1 (rs)
//  - RA2    in   ADDR_W  read address, port 2 (rt)
//  - WA     in   ADDR_W  write address (rt or rd, already muxed)
//  - WD     in   DATA_W  write data from the write-back mux
//  - WE     in   1       write enable (RegWrite)
//  - RD1    out  DATA_W  read data, port 1
//  - RD2    out  DATA_W  read data, port 2
//  - WCNT   out  16      count of committed writes; debug/verification aid
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset is asynchronous and active-low.
//  - On rst_n=0, immediately, regardless of clk:
//    - every register is cleared to 0;
//    - WCNT is cleared to 0;
//    - RD1/RD2 therefore read 0 for any address.
//  - Deassertion of rst_n takes effect at the next rising clk edge. The first write is possible on that edge.
//  - Read: RD1 = reg[RA1] and RD2 = reg[RA2], purely combinational with 0-cycle latency. There are no read enables.
//  - Address 0: RD1/RD2 = 0 whenever the read address is 0, independent of storage contents.
//  - Write: on a rising clk edge with WE=1 and WA!=0, reg[WA] <= WD.
//    - The new value is visible on the read ports after that edge.
//    - WE=1 with WA=0 is a legal no-op: nothing is stored and WCNT does not increment.
//  - WCNT increments by 1 on each committed write (WE=1, WA!=0). It wraps 0xFFFF -> 0x0000 with no flag.
//  - Read-during-write to the same address, same cycle:
//    - BYPASS=0: the read returns the old value until the edge.
//    - BYPASS=1: the read returns WD when WE=1, WA!=0 and RA==WA; both ports apply this independently.
//  - Both read ports may address the same register, or the write address; the ports never interfere.
//  - Reset asserted while WE=1: reset wins; the pending write is discarded.
//  - X/Z on WA while WE=0 must not corrupt state. The bench flags X on WE.
// STRUCTURE
//  - Shared package mips_pkg holds:
//    - DATA_W and ADDR_W defaults;
//    - localparam REG_ZERO = 5'd0;
//    - register aliases (REG_SP = 29, REG_RA = 31) for bench and decode reuse.
//  - Storage: one array reg [DATA_W-1:0] rf [1:2**ADDR_W-1]. Entry 0 is not stored.
//  - Sub-module regfile_read_port (instanced twice):
//    - array lookup;
//    - zero-address forcing;
//    - optional BYPASS compare/select.
//  - The write logic and WCNT live in the top level.
// TESTING
//  1. Reset: hold rst_n=0 for 20 ns, then release; RA1=7, RA2=31 -> RD1=RD2=0, WCNT=0.
//  2. Write/read: WE=1, WA=8, WD=0xDEADBEEF, one edge; RA1=8 -> RD1=0xDEADBEEF, WCNT=1.
//  3. $0 protection: WE=1, WA=0, WD=0xFFFFFFFF, one edge; RA1=RA2=0 -> RD1=RD2=0, WCNT unchanged.
//  4. Same-cycle read/write: WA=RA1=RA2=9, reg[9] held 0x11, WD=0x22, WE=1.
//     - Before the edge: BYPASS=0 -> 0x11; BYPASS=1 -> 0x22.
//     - After the edge: 0x22 on both ports.
//  5. Async reset mid-operation: write 0x1234 to reg 5, then pull rst_n low between edges.
//     - RD1(RA1=5) is 0 within 1 ns, before any clk edge.
//     - WCNT=0.
//  6. Sweep: write reg[i]=i*0x01010101 for i=1..31, then read all pairs (i, 31-i).
//     - Every value matches.
//     - WCNT=31.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: default widths and register aliases.
package mips_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array lookup, $0 forcing, optional write-through.
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter bit          BYPASS = 1'b0
) (
  input  logic [DATA_W-1:0] rf_i [1:(2**ADDR_W)-1],
  input  logic [ADDR_W-1:0] ra_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              we_i,
  output logic [DATA_W-1:0] rd_o
);

  // $0 reads as zero; with BYPASS a same-cycle write to ra is returned directly.
  // ra != 0 together with wa == ra already implies wa != 0.
  always_comb begin
    rd_o = '0;
    if (ra_i != ADDR_W'(REG_ZERO)) begin
      if (BYPASS && we_i && (wa_i == ra_i)) begin
        rd_o = wd_i;
      end else begin
        rd_o = rf_i[ra_i];
      end
    end
  end

endmodule

// File: rtl/mips_register_file.sv
// 32-entry MIPS register file: two combinational reads, one synchronous write,
// $0 hardwired to zero, and a wrapping count of committed writes.
module mips_register_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter bit          BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic              WE,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [15:0]       WCNT
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Entry 0 is never stored.
  logic [DATA_W-1:0] rf_q [1:DEPTH-1];
  logic [15:0]       wcnt_q;
  logic              commit;

  // Writes to $0 are legal no-ops and are not counted.
  assign commit = WE && (WA != ADDR_W'(REG_ZERO));

  // Storage and write counter; reset discards any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        rf_q[i] <= '0;
      end
      wcnt_q <= '0;
    end else if (commit) begin
      rf_q[WA] <= WD;
      wcnt_q   <= wcnt_q + 16'd1;
    end
  end

  assign WCNT = wcnt_q;

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port1 (
    .rf_i (rf_q),
    .ra_i (RA1),
    .wa_i (WA),
    .wd_i (WD),
    .we_i (WE),
    .rd_o (RD1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port2 (
    .rf_i (rf_q),
    .ra_i (RA2),
    .wa_i (WA),
    .wd_i (WD),
    .we_i (WE),
    .rd_o (RD2)
  );

endmodule
